// File: rtl/anubis_round_engine.sv
// anubis_round_engine: iterative Anubis block cipher datapath, one round per clock.
// The round key for the current step is requested on rk_idx and consumed
// combinationally from rk_dat. Decryption runs on the same datapath; the key
// source supplies the inverse key schedule.
// Optional feature: define ANUBIS_ABORT_EN to add the abort input.
module anubis_round_engine #(
    parameter int ROUNDS = 12,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_dat,
    output logic [IDXW-1:0] rk_idx,
    input  logic [127:0]    rk_dat,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef ANUBIS_ABORT_EN
    input  logic            abort,
`endif
    output logic [127:0]    out_dat
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Involutional S-box, row-major: entry x sits at bits [8*(255-x) +: 8]
    localparam logic [2047:0] SBOX = {
        128'hba542f7453d3d24d50ac8dbf70529a4c,
        128'head597d133515ba6de48a899db32b7fc,
        128'he39e919be2bb416ea5cb6b95a1f3b102,
        128'hccc41d14c363da5d5fdc7dcd7f5a6c5c,
        128'hf726ffede89d6f8e19a0f0890f07affb,
        128'h08150d040164df7679dd3d163f376d38,
        128'hb973e93555717b8c7288f62a3e5e2746,
        128'h0c65686103c157d6d958d866d73ac83c,
        128'hfa96a798ecb8c7ae694baba9670a47f2,
        128'hb522e5eebe2b8112831b0e23f54521ce,
        128'h492cf9e6b62817821a8bfe8a09c9874e,
        128'he12ee4e0eb90a41e85600025f4f1940b,
        128'he775ef3431d4d0867eadfd29303b9ff8,
        128'hc6130605c511777c7a78361c39591856,
        128'hb3b02420b292a3c0446210b4844393c2,
        128'h4abd8f2dbc9c6a40cfa2804f1fcaaa42
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    endfunction

    // Byte n of a block, byte 0 being the most significant (state a[n/4][n%4])
    function automatic logic [7:0] byte_of(input logic [127:0] v, input int unsigned n);
        return v[8*(15-n) +: 8];
    endfunction

    state_t          fsm;
    logic [IDXW-1:0] r;
    logic [127:0]    st;
    logic [127:0]    gt_vec;
    logic [127:0]    th_vec;
    logic [127:0]    round_nxt;
    logic            last;
    logic            abort_req;

`ifdef ANUBIS_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign rk_idx  = r;
    assign out_dat = st;

    // Round datapath: tau(gamma(st)) is shared; theta is bypassed on the last round
    always_comb begin
        gt_vec = '0;
        th_vec = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                gt_vec[8*(15-(4*i+j)) +: 8] = sbox(byte_of(st, 4*j+i));
            end
        end
        // Row times the Hadamard matrix had(1,2,4,6): coefficient h[k^j]
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                th_vec[8*(15-(4*i+j)) +: 8] =
                    byte_of(gt_vec, 4*i+j)
                    ^ xt(byte_of(gt_vec, 4*i+(j^1)))
                    ^ xt(xt(byte_of(gt_vec, 4*i+(j^2))))
                    ^ xt(xt(byte_of(gt_vec, 4*i+(j^3))))
                    ^ xt(byte_of(gt_vec, 4*i+(j^3)));
            end
        end
        last      = (r == IDXW'(ROUNDS));
        round_nxt = (last ? gt_vec : th_vec) ^ rk_dat;
    end

    // Control FSM with registered handshake outputs and state register
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            r         <= '0;
            st        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && !abort_req) begin
                        st       <= in_dat ^ rk_dat;
                        r        <= IDXW'(1);
                        fsm      <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        fsm      <= IDLE;
                        r        <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        st <= round_nxt;
                        if (last) begin
                            r         <= '0;
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort_req || out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anubis_round_engine.sv
// tb_anubis_round_engine: directed bench for anubis_round_engine with a
// behavioural Anubis reference (table S-box, generic GF multiply).
// Exercises abort as well when ANUBIS_ABORT_EN is defined.
module tb_anubis_round_engine;

    localparam int R  = 12;
    localparam int RB = 18;

    localparam logic [127:0] SB_ROWS [16] = '{
        128'hba542f7453d3d24d50ac8dbf70529a4c, 128'head597d133515ba6de48a899db32b7fc,
        128'he39e919be2bb416ea5cb6b95a1f3b102, 128'hccc41d14c363da5d5fdc7dcd7f5a6c5c,
        128'hf726ffede89d6f8e19a0f0890f07affb, 128'h08150d040164df7679dd3d163f376d38,
        128'hb973e93555717b8c7288f62a3e5e2746, 128'h0c65686103c157d6d958d866d73ac83c,
        128'hfa96a798ecb8c7ae694baba9670a47f2, 128'hb522e5eebe2b8112831b0e23f54521ce,
        128'h492cf9e6b62817821a8bfe8a09c9874e, 128'he12ee4e0eb90a41e85600025f4f1940b,
        128'he775ef3431d4d0867eadfd29303b9ff8, 128'hc6130605c511777c7a78361c39591856,
        128'hb3b02420b292a3c0446210b4844393c2, 128'h4abd8f2dbc9c6a40cfa2804f1fcaaa42
    };
    localparam logic [7:0] HV [4] = '{8'h01, 8'h02, 8'h04, 8'h06};

    logic         clk, reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_dat, rk_dat, out_dat;
    logic [4:0]   rk_idx;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [127:0] rk_dat_b, out_dat_b;
    logic [4:0]   rk_idx_b;
`ifdef ANUBIS_ABORT_EN
    logic         abort;
`endif
    logic [127:0] ks [32];
    int unsigned  n_chk, n_pass;

    assign rk_dat   = ks[rk_idx];
    assign rk_dat_b = ks[rk_idx_b];

    anubis_round_engine #(.ROUNDS(R), .IDXW(5)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_dat(in_dat), .rk_idx(rk_idx), .rk_dat(rk_dat),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef ANUBIS_ABORT_EN
        .abort(abort),
`endif
        .out_dat(out_dat)
    );

    anubis_round_engine #(.ROUNDS(RB), .IDXW(5)) u_dut18 (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_dat(in_dat), .rk_idx(rk_idx_b), .rk_dat(rk_dat_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
`ifdef ANUBIS_ABORT_EN
        .abort(1'b0),
`endif
        .out_dat(out_dat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SB_ROWS[x[7:4]];
        return row[8*(15-int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1d) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] m_gamma(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[8*(15-n) +: 8] = ref_sbox(v[8*(15-n) +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] m_tau(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                o[8*(15-(4*i+j)) +: 8] = v[8*(15-(4*j+i)) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_theta(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(v[8*(15-(4*i+k)) +: 8], HV[k ^ j]);
                o[8*(15-(4*i+j)) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] blk, input int nr);
        logic [127:0] s;
        s = blk ^ ks[0];
        for (int r = 1; r <= nr; r++) begin
            s = m_tau(m_gamma(s));
            if (r < nr) s = m_theta(s);
            s = s ^ ks[r];
        end
        return s;
    endfunction

    // One block through either instance; call at a negedge with the engine idle
    task automatic run_block(input bit big, input logic [127:0] blk, output logic [127:0] res);
        int n;
        n = 0;
        while (!(big ? in_ready_b : in_ready) && n < 100) begin @(negedge clk); n++; end
        in_dat = blk;
        if (big) in_valid_b = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        n = 0;
        while (!(big ? out_valid_b : out_valid) && n < 100) begin @(negedge clk); n++; end
        check("result_valid_seen", big ? out_valid_b : out_valid, 1'b1);
        res = big ? out_dat_b : out_dat;
        if (big) out_ready_b = 1'b1; else out_ready = 1'b1;
        @(negedge clk);
        out_ready   = 1'b0;
        out_ready_b = 1'b0;
    endtask

    initial begin
        logic [127:0] ones, exp, res, p, ct, snap, blk_a, blk_b, res_a, res_b;
        logic [127:0] ksi [32];
        logic [31:0]  w;
        int           n, acc0, acc1, na, nr;
        logic         seen;

        n_chk = 0; n_pass = 0;
        ones = '1;
        reset = 1'b1; in_valid = 1'b0; in_dat = '0; out_ready = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0;
`ifdef ANUBIS_ABORT_EN
        abort = 1'b0;
`endif
        for (int unsigned r = 0; r < 32; r++) ks[r] = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_dat", out_dat, '0);
        check("rst_rk_idx", rk_idx, 5'd0);
        check("rst_b_out_dat", out_dat_b, '0);
        reset = 1'b0;

        // round-key index sequence, latency, in_valid ignored while busy
        @(negedge clk);
        in_dat = '0; in_valid = 1'b1;
        check("t0_rk_idx", rk_idx, 5'd0);
        check("t0_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_dat = 128'h5555aaaa_0f0f_f0f0_1234_5678_9abc_def0;
        for (int k = 1; k <= R; k++) begin
            check("run_rk_idx", rk_idx, 128'(k));
            check("run_in_ready", in_ready, 1'b0);
            check("run_out_valid", out_valid, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp = ref_enc('0, R);
        check("done_out_valid", out_valid, 1'b1);
        check("done_in_ready", in_ready, 1'b0);
        check("done_rk_idx", rk_idx, 5'd0);
        check("enc_zero_r12", out_dat, exp);

        // output held while consumer stalls
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_out_dat", out_dat, exp);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready", in_ready, 1'b1);

        // zero schedule is its own inverse: decrypting returns the plaintext
        run_block(1'b0, exp, res);
        check("dec_zero_r12", res, '0);
        run_block(1'b0, ones, res);
        check("enc_ones_r12", res, ref_enc(ones, R));
        run_block(1'b0, ref_enc(ones, R), res);
        check("dec_ones_r12", res, ones);

        // non-trivial schedule and its inverse K'0=KR, K'R=K0, K'r=theta(K(R-r))
        for (int unsigned r = 0; r <= R; r++) begin
            w = 32'h9e3779b9 * (r + 1);
            ks[r] = {w, ~w, w ^ 32'h5a5a5a5a, w[15:0], w[31:16]};
        end
        p = 128'h00112233_44556677_8899aabb_ccddeeff;
        ct = ref_enc(p, R);
        run_block(1'b0, p, res);
        check("enc_keyed_r12", res, ct);
        ksi[0] = ks[R];
        ksi[R] = ks[0];
        for (int r = 1; r < R; r++) ksi[r] = m_theta(ks[R - r]);
        for (int r = 0; r <= R; r++) ks[r] = ksi[r];
        run_block(1'b0, ct, res);
        check("dec_keyed_r12", res, p);
        for (int unsigned r = 0; r < 32; r++) ks[r] = '0;

        // back-to-back blocks with the consumer always ready
        blk_a = 128'hdeadbeef_00000000_ffffffff_01234567;
        blk_b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        acc0 = 0; acc1 = 0; na = 0; nr = 0; res_a = '0; res_b = '0;
        out_ready = 1'b1; in_dat = blk_a; in_valid = 1'b1;
        for (int c = 0; c < 80 && nr < 2; c++) begin
            if (na == 1) in_dat = blk_b;
            if (na == 2) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (na == 0) acc0 = c; else acc1 = c;
                na++;
            end
            if (out_valid) begin
                if (nr == 0) res_a = out_dat; else res_b = out_dat;
                nr++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check("b2b_results", 128'(nr), 128'd2);
        check("b2b_interval", 128'(acc1 - acc0), 128'(R + 2));
        check("b2b_res_a", res_a, ref_enc(blk_a, R));
        check("b2b_res_b", res_b, ref_enc(blk_b, R));

        // reset in the middle of a block
        in_dat = blk_a; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 5'd5 && n < 40) begin @(negedge clk); n++; end
        check("mid_reach_r5", rk_idx, 5'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_dat", out_dat, '0);
        check("mid_rst_rk_idx", rk_idx, 5'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        run_block(1'b0, blk_b, res);
        check("after_rst_block", res, ref_enc(blk_b, R));

`ifdef ANUBIS_ABORT_EN
        // abort mid-block, then abort racing in_valid in IDLE
        in_dat = blk_a; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 5'd7 && n < 40) begin @(negedge clk); n++; end
        check("abort_reach_r7", rk_idx, 5'd7);
        snap = out_dat;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_rk_idx", rk_idx, 5'd0);
        check("abort_state_kept", out_dat, snap);
        seen = 1'b0;
        for (int k = 0; k < R + 3; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("abort_no_out_valid", seen, 1'b0);
        in_dat = blk_b; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        check("abort_idle_rk_idx", rk_idx, 5'd0);
        check("abort_idle_in_ready", in_ready, 1'b1);
        check("abort_idle_no_load", out_dat, snap);
        run_block(1'b0, blk_a, res);
        check("after_abort_block", res, ref_enc(blk_a, R));
`endif

        // 18-round instance, zero schedule
        run_block(1'b1, '0, res);
        check("enc_zero_r18", res, ref_enc('0, RB));
        run_block(1'b1, ref_enc('0, RB), res);
        check("dec_zero_r18", res, '0);
        run_block(1'b1, ones, res);
        check("enc_ones_r18", res, ref_enc(ones, RB));
        run_block(1'b1, ref_enc(ones, RB), res);
        check("dec_ones_r18", res, ones);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
